// File: rtl/nios_system_game_tick_sequencer.sv
// nios_system_game_tick_sequencer
// Sole bus master of a 16-bit interval timer. A start programs the period,
// clears status and runs the timer in continuous IRQ mode. Each timer IRQ is
// acknowledged with a status clear and turned into a one-cycle game tick.
// Stop halts the timer and returns to idle.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   cfg_period[31:0]    timer load value, latched on an accepted start
//   cfg_start/cfg_stop  start (IDLE only) / stop (any non-IDLE state) pulses
//   tick_ack            consumer has taken the pending tick
//   busy                high whenever the sequencer is not idle
//   tick                one-cycle pulse per serviced IRQ
//   tick_pending        set by tick, cleared by tick_ack
//   tick_count          ticks since the last accepted start (wraps)
//   overrun_count       ticks raised while a tick was pending (saturates)
//   tmr_*               timer slave bus (address, chipselect, write_n, data)
//   tmr_irq             timer interrupt, level
module nios_system_game_tick_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      cfg_period,
    input  logic             cfg_start,
    input  logic             cfg_stop,
    input  logic             tick_ack,
    output logic             busy,
    output logic             tick,
    output logic             tick_pending,
    output logic [CNT_W-1:0] tick_count,
    output logic [CNT_W-1:0] overrun_count,
    output logic [2:0]       tmr_address,
    output logic             tmr_chipselect,
    output logic             tmr_write_n,
    output logic [15:0]      tmr_writedata,
    input  logic             tmr_irq
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_S_STOP,
        ST_S_PL,
        ST_S_PH,
        ST_S_CLR,
        ST_S_CTL,
        ST_RUN,
        ST_ACK,
        ST_HALT,
        ST_H_CLR
    } state_t;

    state_t             r_state;
    state_t             w_nx;
    logic               w_start_acc;
    logic               w_wr;
    logic [2:0]         w_addr;
    logic [15:0]        w_data;
    logic               w_stop_src;

    logic [31:0]        r_period;
    logic               r_stop_req;
    logic               r_busy;
    logic               r_tick;
    logic               r_pending;
    logic [CNT_W-1:0]   r_tick_count;
    logic [CNT_W-1:0]   r_overrun;
    logic [2:0]         r_addr;
    logic               r_cs;
    logic               r_write_n;
    logic [15:0]        r_data;

    // Next state
    always_comb begin
        w_nx = r_state;
        case (r_state)
            ST_IDLE:   if (cfg_start && !cfg_stop && (cfg_period != '0)) w_nx = ST_S_STOP;
            ST_S_STOP: w_nx = ST_S_PL;
            ST_S_PL:   w_nx = ST_S_PH;
            ST_S_PH:   w_nx = ST_S_CLR;
            ST_S_CLR:  w_nx = ST_S_CTL;
            ST_S_CTL:  w_nx = ST_RUN;
            // Stop has priority over a pending IRQ: no tick on the way out.
            ST_RUN: begin
                if (r_stop_req || cfg_stop) w_nx = ST_HALT;
                else if (tmr_irq)           w_nx = ST_ACK;
            end
            ST_ACK:    w_nx = ST_RUN;
            ST_HALT:   w_nx = ST_H_CLR;
            ST_H_CLR:  w_nx = ST_IDLE;
            default:   w_nx = ST_IDLE;
        endcase
    end

    assign w_start_acc = (r_state == ST_IDLE) && (w_nx == ST_S_STOP);

    // Stop requests arriving mid-sequence are remembered until RUN.
    assign w_stop_src = cfg_stop && (r_state inside {ST_S_STOP, ST_S_PL, ST_S_PH,
                                                     ST_S_CLR, ST_S_CTL, ST_ACK});

    // Bus word for the state being entered; registered so each state
    // presents its own write for exactly one cycle.
    always_comb begin
        w_wr   = 1'b1;
        w_addr = 3'd0;
        w_data = 16'h0000;
        case (w_nx)
            ST_S_STOP, ST_HALT: begin w_addr = 3'd1; w_data = 16'h0008; end
            ST_S_PL:            begin w_addr = 3'd2; w_data = r_period[15:0]; end
            ST_S_PH:            begin w_addr = 3'd3; w_data = r_period[31:16]; end
            ST_S_CLR, ST_ACK, ST_H_CLR: begin w_addr = 3'd0; w_data = 16'h0000; end
            ST_S_CTL:           begin w_addr = 3'd1; w_data = 16'h0007; end
            default:            w_wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_period     <= '0;
            r_stop_req   <= 1'b0;
            r_busy       <= 1'b0;
            r_tick       <= 1'b0;
            r_pending    <= 1'b0;
            r_tick_count <= '0;
            r_overrun    <= '0;
            r_addr       <= '0;
            r_cs         <= 1'b0;
            r_write_n    <= 1'b1;
            r_data       <= '0;
        end else begin
            r_state   <= w_nx;
            r_busy    <= (w_nx != ST_IDLE);
            r_tick    <= (r_state == ST_RUN) && (w_nx == ST_ACK);
            r_cs      <= w_wr;
            r_write_n <= ~w_wr;
            r_addr    <= w_wr ? w_addr : 3'd0;
            r_data    <= w_wr ? w_data : 16'h0000;

            if (r_state == ST_H_CLR)
                r_stop_req <= 1'b0;
            else if (w_stop_src)
                r_stop_req <= 1'b1;

            if (w_start_acc) begin
                r_period     <= cfg_period;
                r_tick_count <= '0;
                r_overrun    <= '0;
                r_pending    <= 1'b0;
            end else if (r_tick) begin
                r_tick_count <= r_tick_count + CNT_W'(1);
                // A tick acked in its own cycle keeps pending set, no overrun.
                if (!r_pending)
                    r_pending <= 1'b1;
                else if (!tick_ack && (r_overrun != '1))
                    r_overrun <= r_overrun + CNT_W'(1);
            end else if (tick_ack) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign busy           = r_busy;
    assign tick           = r_tick;
    assign tick_pending   = r_pending;
    assign tick_count     = r_tick_count;
    assign overrun_count  = r_overrun;
    assign tmr_address    = r_addr;
    assign tmr_chipselect = r_cs;
    assign tmr_write_n    = r_write_n;
    assign tmr_writedata  = r_data;

endmodule
